// File: rtl/pucch_block_encoder_pkg.sv
// pucch_block_encoder_pkg: shared constants, FSM state type and reference
// encoder for the (20,A) PUCCH Reed-Muller block code.
//   RM_BASIS[i] holds row i of the basis table, M(i,0) in the MSB.
//   rm_encode(bits, a) returns b[19:0], b_i = XOR over n<a of a_n & M(i,n),
//   with a_n = bits[15-n] (MSB-first info word).
package pucch_block_encoder_pkg;

    localparam int NUM_SYMBOLS_C   = 20;
    localparam int MAX_INFO_BITS_C = 13;

    typedef enum logic [1:0] {IDLE, ENCODE, SEND} state_t;

    localparam logic [12:0] RM_BASIS [NUM_SYMBOLS_C] = '{
        13'b1100000000110,
        13'b1110000001110,
        13'b1001001011111,
        13'b1011000010111,
        13'b1111000100111,
        13'b1100101110111,
        13'b1010101011111,
        13'b1001100110111,
        13'b1101100101111,
        13'b1011101001111,
        13'b1010011101111,
        13'b1110011010111,
        13'b1001010111111,
        13'b1101010101111,
        13'b1000110100101,
        13'b1100111101101,
        13'b1110111001011,
        13'b1001110010011,
        13'b1101111100000,
        13'b1000011000000
    };

    function automatic logic [NUM_SYMBOLS_C-1:0] rm_encode(logic [15:0] bits, int a);
        logic [NUM_SYMBOLS_C-1:0] b;
        b = '0;
        for (int i = 0; i < NUM_SYMBOLS_C; i++)
            for (int n = 0; n < MAX_INFO_BITS_C; n++)
                if (n < a)
                    b[i] = b[i] ^ (bits[15-n] & RM_BASIS[i][12-n]);
        return b;
    endfunction

endpackage

// File: rtl/pucch_block_encoder_if.sv
// pucch_block_encoder_if: info-word input stream and coded-symbol output stream.
//   code_length     A, sampled with the input handshake
//   s_axis_*        16-bit info word stream (tlast ignored)
//   m_axis_*        DATA_WIDTH-bit symbol stream, tlast on the last symbol
//   master: the side feeding words and consuming symbols; slave: the encoder.
interface pucch_block_encoder_if #(parameter int DATA_WIDTH = 8);

    logic [7:0]            code_length;
    logic [15:0]           s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic                  s_axis_tlast;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        output code_length, s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        input  code_length, s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

endinterface

// File: rtl/pucch_block_encoder_core.sv
// block_enc_core: combinational 13x20 GF(2) matrix product of the info word
// with the Reed-Muller basis; the caller registers the result.
//   bits  in  16  info word, a_n at bit [15-n]
//   a     in  4   number of info bits, already clamped to 0..13
//   code  out 20  codeword, b_i at bit i
module block_enc_core
    import pucch_block_encoder_pkg::*;
(
    input  logic [15:0]              bits,
    input  logic [3:0]               a,
    output logic [NUM_SYMBOLS_C-1:0] code
);

    always_comb code = rm_encode(bits, int'(a));

endmodule

// File: rtl/pucch_block_encoder.sv
// pucch_block_encoder: (20,A) PUCCH Reed-Muller encoder with antipodal soft output.
//   clk   in  1   clock
//   arst  in  1   asynchronous active-high reset
//   bus   slave modport of pucch_block_encoder_if (info word in, symbols out)
// Build option BLOCK_ENC_HARD_BITS_EN: when defined, symbols are the raw code
// bits {0..0, b_i} instead of +/-AMPLITUDE; handshake and timing are unchanged.
module pucch_block_encoder
    import pucch_block_encoder_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_SYMBOLS   = 20,
    parameter int MAX_INFO_BITS = 13,
    parameter int AMPLITUDE     = 64
) (
    input logic                 clk,
    input logic                 arst,
    pucch_block_encoder_if.slave bus
);

    state_t                   state;
    logic [15:0]              info;
    logic [3:0]               a_len;
    logic [NUM_SYMBOLS_C-1:0] codeword;
    logic [NUM_SYMBOLS_C-1:0] code;
    logic [4:0]               cnt;
    logic [4:0]               cnt_next;
    logic [DATA_WIDTH-1:0]    m_tdata;
    logic                     m_tvalid;
    logic                     m_tlast;
    logic                     unused_tlast;

`ifndef BLOCK_ENC_HARD_BITS_EN
    localparam logic [DATA_WIDTH-1:0] POS = DATA_WIDTH'(AMPLITUDE);
    localparam logic [DATA_WIDTH-1:0] NEG = DATA_WIDTH'(-AMPLITUDE);
`endif

    // positive symbol carries bit 0, matching the decoder's convention
    function automatic logic [DATA_WIDTH-1:0] to_sym(logic b);
`ifdef BLOCK_ENC_HARD_BITS_EN
        return {{(DATA_WIDTH-1){1'b0}}, b};
`else
        return b ? NEG : POS;
`endif
    endfunction

    block_enc_core u_core (
        .bits (info),
        .a    (a_len),
        .code (code)
    );

    assign cnt_next           = cnt + 5'd1;
    assign unused_tlast       = bus.s_axis_tlast;
    assign bus.s_axis_tready  = state == IDLE;
    assign bus.m_axis_tdata   = m_tdata;
    assign bus.m_axis_tvalid  = m_tvalid;
    assign bus.m_axis_tlast   = m_tlast;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= IDLE;
            info     <= '0;
            a_len    <= '0;
            codeword <= '0;
            cnt      <= '0;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.s_axis_tvalid) begin
                    info  <= bus.s_axis_tdata;
                    a_len <= bus.code_length > 8'(MAX_INFO_BITS) ? 4'(MAX_INFO_BITS) : bus.code_length[3:0];
                    state <= ENCODE;
                end
                ENCODE: begin
                    codeword <= code;
                    state    <= SEND;
                end
                SEND: if (!m_tvalid) begin
                    // first SEND cycle loads symbol 0 so valid appears two cycles after accept
                    m_tvalid <= 1'b1;
                    m_tdata  <= to_sym(codeword[cnt]);
                    m_tlast  <= cnt == 5'(NUM_SYMBOLS - 1);
                end else if (bus.m_axis_tready) begin
                    if (m_tlast) begin
                        m_tvalid <= 1'b0;
                        m_tlast  <= 1'b0;
                        cnt      <= '0;
                        state    <= IDLE;
                    end else begin
                        cnt     <= cnt_next;
                        m_tdata <= to_sym(codeword[cnt_next]);
                        m_tlast <= cnt_next == 5'(NUM_SYMBOLS - 1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pucch_block_encoder.sv
// tb_pucch_block_encoder: vector table, hand sequences and randomized words
// checked against a parity-count model of the PUCCH Reed-Muller code.
module tb_pucch_block_encoder;

    localparam int DW  = 8;
    localparam int AMP = 64;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
        int          lo;
        int          hi;
        logic [19:0] exp;
    } vec_t;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [12:0] basis [20];

    always #5 clk = ~clk;

    pucch_block_encoder_if #(.DATA_WIDTH(DW)) bus();

    pucch_block_encoder #(
        .DATA_WIDTH(DW), .NUM_SYMBOLS(20), .MAX_INFO_BITS(13), .AMPLITUDE(AMP)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // b_i is the parity of how many selected info bits hit a one in basis row i
    function automatic logic [19:0] model(logic [7:0] a, logic [15:0] d);
        logic [19:0] r;
        int k;
        int ones;
        k = a > 13 ? 13 : int'(a);
        r = '0;
        for (int i = 0; i < 20; i++) begin
            ones = 0;
            for (int n = 0; n < k; n++)
                if (d[15-n] && basis[i][12-n]) ones++;
            r[i] = (ones % 2) == 1;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] exp_sym(bit b);
`ifdef BLOCK_ENC_HARD_BITS_EN
        return b ? DW'(1) : DW'(0);
`else
        return b ? DW'(-AMP) : DW'(AMP);
`endif
    endfunction

    task automatic run_word(input logic [7:0] a, input logic [15:0] d, input int lo, input int hi,
                            output logic [19:0] bits, output int lat, output int perr);
        int  w;
        int  cyc;
        int  k;
        bit  acc;
        bit  pv;
        bit  pr;
        bit  pl;
        logic [DW-1:0] pd;
        bits = '0; lat = -1; perr = 0; w = 0; cyc = 0; k = 0; acc = 0;
        pv = 0; pr = 0; pl = 0; pd = '0;
        @(posedge clk); #1;
        bus.code_length   = a;
        bus.s_axis_tdata  = d;
        bus.s_axis_tvalid = 1'b1;
        bus.m_axis_tready = lo == 0;
        while (!acc && w < 100) begin
            @(negedge clk);
            acc = bus.s_axis_tready;
            @(posedge clk); #1;
            w++;
        end
        bus.s_axis_tvalid = 1'b0;
        bus.code_length   = 8'($urandom);
        bus.s_axis_tdata  = 16'($urandom);
        if (!acc) begin
            check(0, "accept_timeout", w, 100);
            perr = 1000;
            return;
        end
        while (k < 20 && cyc < 2000) begin
            @(negedge clk);
            if (bus.m_axis_tvalid && lat < 0) lat = cyc;
            if (pv && !pr && (!bus.m_axis_tvalid || bus.m_axis_tdata != pd || bus.m_axis_tlast != pl)) perr++;
            if (bus.s_axis_tready) perr++;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                if (bus.m_axis_tdata == exp_sym(1)) bits[k] = 1'b1;
                else if (bus.m_axis_tdata != exp_sym(0)) perr++;
                if (bus.m_axis_tlast != (k == 19)) perr++;
                k++;
            end
            pv = bus.m_axis_tvalid; pr = bus.m_axis_tready;
            pd = bus.m_axis_tdata;  pl = bus.m_axis_tlast;
            @(posedge clk); #1;
            cyc++;
            bus.m_axis_tready = lo == 0 || (cyc % (lo + hi)) >= lo;
        end
        if (k < 20) begin
            check(0, "beat_timeout", k, 20);
            perr += 1000;
        end else begin
            @(negedge clk);
            if (!bus.s_axis_tready || bus.m_axis_tvalid) perr++;
        end
        bus.m_axis_tready = 1'b1;
    endtask

    initial begin
        vec_t        tbl [8];
        logic [19:0] got;
        logic [19:0] got2;
        logic [7:0]  a;
        logic [7:0]  a2;
        logic [15:0] d;
        logic [15:0] d2;
        logic [15:0] mask;
        int          lat;
        int          perr;
        int          ac;
        int          beats;
        basis = '{
            13'b1100000000110, 13'b1110000001110, 13'b1001001011111, 13'b1011000010111,
            13'b1111000100111, 13'b1100101110111, 13'b1010101011111, 13'b1001100110111,
            13'b1101100101111, 13'b1011101001111, 13'b1010011101111, 13'b1110011010111,
            13'b1001010111111, 13'b1101010101111, 13'b1000110100101, 13'b1100111101101,
            13'b1110111001011, 13'b1001110010011, 13'b1101111100000, 13'b1000011000000
        };
        tbl[0] = '{8'd1,   16'h8000, 0,  0,  20'hFFFFF};
        tbl[1] = '{8'd13,  16'h0000, 0,  0,  20'h00000};
        tbl[2] = '{8'd0,   16'hFFFF, 0,  0,  20'h00000};
        tbl[3] = '{8'd10,  16'h8000, 20, 10, 20'hFFFFF};
        tbl[4] = '{8'd2,   16'h4000, 0,  0,  20'h5A933};
        tbl[5] = '{8'd14,  16'h8000, 0,  0,  20'hFFFFF};
        tbl[6] = '{8'd200, 16'h8000, 0,  0,  20'hFFFFF};
        tbl[7] = '{8'd1,   16'hFFFF, 0,  0,  20'hFFFFF};

        bus.code_length = '0; bus.s_axis_tdata = '0; bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast = 1'b0; bus.m_axis_tready = 1'b1;
        #12;
        check(bus.m_axis_tvalid == 1'b0, "reset_tvalid", bus.m_axis_tvalid, 0);
        check(bus.m_axis_tlast == 1'b0,  "reset_tlast",  bus.m_axis_tlast, 0);
        check(bus.m_axis_tdata == '0,    "reset_tdata",  bus.m_axis_tdata, 0);
        @(negedge clk); arst = 1'b0;
        @(negedge clk);
        check(bus.s_axis_tready == 1'b1, "reset_tready", bus.s_axis_tready, 1);

        for (int i = 0; i < 8; i++) begin
            run_word(tbl[i].a, tbl[i].d, tbl[i].lo, tbl[i].hi, got, lat, perr);
            check(got == tbl[i].exp, $sformatf("vec%0d_bits", i), got, tbl[i].exp);
            check(lat == 2,          $sformatf("vec%0d_latency", i), lat, 2);
            check(perr == 0,         $sformatf("vec%0d_protocol", i), perr, 0);
        end

        for (int t = 0; t < 1000; t++) begin
            a = 8'($urandom_range(0, 15));
            d = 16'($urandom);
            run_word(a, d, ($urandom % 8 == 0) ? 1 : 0, 2, got, lat, perr);
            check(got == model(a, d), "rand_bits", got, model(a, d));
            check(perr == 0 && lat == 2, "rand_protocol", perr * 100 + lat, 2);
            if (t % 4 == 0) begin
                ac   = a > 13 ? 13 : int'(a);
                mask = ac == 0 ? 16'hFFFF : (16'hFFFF >> ac);
                d2   = (d & ~mask) | (16'($urandom) & mask);
                a2   = ac == 13 ? 8'(13 + $urandom_range(0, 242)) : a;
                run_word(a2, d2, 0, 1, got2, lat, perr);
                check(got2 == got, "mask_clamp_bits", got2, got);
            end
        end

        // reset in the middle of a codeword
        @(posedge clk); #1;
        bus.code_length = 8'd13; bus.s_axis_tdata = 16'hA5C3; bus.s_axis_tvalid = 1'b1;
        bus.m_axis_tready = 1'b1;
        @(posedge clk); #1;
        bus.s_axis_tvalid = 1'b0;
        beats = 0;
        for (int c = 0; c < 40 && beats < 7; c++) begin
            @(negedge clk);
            if (bus.m_axis_tvalid) beats++;
        end
        @(posedge clk); #2;
        arst = 1'b1;
        #1;
        check(beats == 7,                "rst_beats_seen", beats, 7);
        check(bus.m_axis_tvalid == 1'b0, "rst_mid_tvalid", bus.m_axis_tvalid, 0);
        check(bus.m_axis_tlast == 1'b0,  "rst_mid_tlast",  bus.m_axis_tlast, 0);
        @(negedge clk); #2;
        arst = 1'b0;
        @(negedge clk);
        check(bus.s_axis_tready == 1'b1, "rst_release_tready", bus.s_axis_tready, 1);
        check(bus.m_axis_tvalid == 1'b0, "rst_release_tvalid", bus.m_axis_tvalid, 0);
        run_word(8'd5, 16'hB800, 0, 0, got, lat, perr);
        check(got == model(8'd5, 16'hB800), "post_rst_bits", got, model(8'd5, 16'hB800));
        check(perr == 0 && lat == 2, "post_rst_protocol", perr * 100 + lat, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
